// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side front end for the 32x32 register file.
// It merges ALU results with in-order load responses, extracts and extends load data, and publishes a load busy mask.
module regfile_writeback #(
    parameter int LQ_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_val,
    input  logic        ld_issue_valid,
    output logic        ld_issue_ready,
    input  logic [4:0]  ld_issue_rd,
    input  logic [2:0]  ld_issue_funct3,
    input  logic [1:0]  ld_issue_offset,
    input  logic        ld_resp_valid,
    output logic        ld_resp_ready,
    input  logic [31:0] ld_resp_data,
    output logic [4:0]  rd_addr,
    output logic [31:0] w_val,
    output logic [31:0] busy_mask,
    output logic        proto_err
);
    localparam int AW = $clog2(LQ_DEPTH);

    logic [4:0]  r_lq_rd  [LQ_DEPTH];
    logic [2:0]  r_lq_f3  [LQ_DEPTH];
    logic [1:0]  r_lq_off [LQ_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic        r_h_v, r_o_ld, r_perr;
    logic [4:0]  r_h_rd, r_rd;
    logic [31:0] r_h_val, r_val;

    logic        w_push, w_acc, w_drop;
    logic [4:0]  w_hrd;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [31:0] w_bsh, w_hsh, w_ext, w_busy;
    logic [7:0]  w_b;
    logic [15:0] w_h;

    assign ld_issue_ready = r_cnt < (AW+1)'(LQ_DEPTH);
    assign ld_resp_ready  = !r_h_v;
    assign w_push = ld_issue_valid && ld_issue_ready;
    assign w_acc  = ld_resp_valid && !r_h_v && r_cnt != '0;
    assign w_drop = ld_resp_valid && !r_h_v && r_cnt == '0;

    assign w_hrd = r_lq_rd[r_rp];
    assign w_f3  = r_lq_f3[r_rp];
    assign w_off = r_lq_off[r_rp];
    assign w_bsh = ld_resp_data >> {w_off, 3'b000};
    assign w_hsh = ld_resp_data >> {w_off[1], 4'b0000};
    assign w_b   = w_bsh[7:0];
    assign w_h   = w_hsh[15:0];
    // funct3 011/110/111 fall through to a full-word load
    assign w_ext = w_f3 == 3'b000 ? {{24{w_b[7]}}, w_b} :
                   w_f3 == 3'b100 ? {24'b0, w_b} :
                   w_f3 == 3'b001 ? {{16{w_h[15]}}, w_h} :
                   w_f3 == 3'b101 ? {16'b0, w_h} : ld_resp_data;

    always_comb begin
        w_busy = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            if ((AW+1)'(i) < r_cnt) w_busy = w_busy | (32'b1 << r_lq_rd[AW'(r_rp + AW'(i))]);
        if (r_h_v) w_busy = w_busy | (32'b1 << r_h_rd);
        if (r_o_ld) w_busy = w_busy | (32'b1 << r_rd);
        w_busy[0] = 1'b0;
    end

    assign busy_mask = w_busy;
    assign rd_addr   = r_rd;
    assign w_val     = r_val;
    assign proto_err = r_perr;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_lq_rd[r_wp]  <= ld_issue_rd;
            r_lq_f3[r_wp]  <= ld_issue_funct3;
            r_lq_off[r_wp] <= ld_issue_offset;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_h_v   <= 1'b0;
            r_h_rd  <= '0;
            r_h_val <= '0;
            r_rd    <= '0;
            r_val   <= '0;
            r_o_ld  <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_wp  <= r_wp + AW'(w_push);
            r_rp  <= r_rp + AW'(w_acc);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_acc);
            if (w_drop) r_perr <= 1'b1;
            if (alu_valid) begin
                r_rd   <= alu_rd;
                r_val  <= alu_val;
                r_o_ld <= 1'b0;
                if (w_acc) begin
                    r_h_v   <= 1'b1;
                    r_h_rd  <= w_hrd;
                    r_h_val <= w_ext;
                end
            end else if (r_h_v) begin
                r_rd   <= r_h_rd;
                r_val  <= r_h_val;
                r_o_ld <= 1'b1;
                r_h_v  <= 1'b0;
            end else begin
                r_rd   <= w_acc ? w_hrd : 5'd0;
                r_val  <= w_acc ? w_ext : 32'd0;
                r_o_ld <= w_acc;
            end
        end
    end
endmodule
